fetch_ctrl: RTL and testbench

//  Sequences the PC register and the instruction-memory handshake for the MIPS front end.

---
 rtl/mips_pkg.sv | 17 +
 rtl/pc_redirect_mux.sv | 30 +++
 rtl/fetch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS front end.
//   fetch_state_t      : fetch sequencer states
//   RESET_VEC_DEFAULT  : PC loaded while reset is high
//   INSTR_INC_DEFAULT  : sequential PC increment in bytes
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStall,
    StDrain
  } fetch_state_t;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_INC_DEFAULT = 32'd4;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select of the front-end redirect sources.
//   exc_*    : exception redirect (highest priority)
//   br_*     : taken branch redirect
//   jmp_*    : jump / jr redirect (lowest priority)
//   redirect : any source active
//   target   : selected target, word aligned
module pc_redirect_mux (
  input  logic        exc_valid,
  input  logic [31:0] exc_vector,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = exc_valid | br_taken | jmp_valid;
    target   = jmp_target;
    if (br_taken) begin
      target = br_target;
    end
    if (exc_valid) begin
      target = exc_vector;
    end
    target[1:0] = 2'b00;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register input, runs the instruction-memory
// request/ack handshake and hands one instruction per accepted fetch to decode.
//   clk, rst              : clock, synchronous active-high reset
//   pc_cur / pc_next      : PC register output / input (register loads every cycle)
//   imem_req/addr/ack/rdata : instruction-memory handshake
//   exc_*, br_*, jmp_*    : redirect sources (exc > br > jmp)
//   if_valid/instr/pc     : instruction slot presented to decode
//   if_stall              : decode back-pressure
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter logic [31:0] INSTR_INC = INSTR_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        exc_valid,
  input  logic [31:0] exc_vector,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_stall
);

  fetch_state_t state_q, state_d;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        redirect;
  logic [31:0] target;
  logic        slot_free;
  logic [31:0] pc_inc;

  pc_redirect_mux u_redirect_mux (
    .exc_valid  (exc_valid),
    .exc_vector (exc_vector),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .redirect   (redirect),
    .target     (target)
  );

  // Slot can take a new word this edge if empty or being consumed now.
  assign slot_free = ~if_valid_q | ~if_stall;
  assign pc_inc    = pc_cur + INSTR_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      if_valid_q   <= 1'b0;
      if_instr_q   <= 32'h0;
      if_pc_q      <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    // A held slot survives only while decode stalls.
    if_valid_d   = if_valid_q & if_stall;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    drain_addr_d = drain_addr_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (redirect) begin
          // Unacked request must still complete at its original address.
          if (!imem_ack) begin
            drain_addr_d = pc_cur;
            state_d      = StDrain;
          end
        end else if (imem_ack) begin
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_cur;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_cur;
            state_d      = StStall;
          end
        end
      end
      StStall: begin
        if (redirect) begin
          state_d = StFetch;
        end else if (!if_stall) begin
          if_valid_d = 1'b1;
          if_instr_d = skid_instr_q;
          if_pc_d    = skid_pc_q;
          state_d    = StFetch;
        end
      end
      StDrain: begin
        if (imem_ack) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
    if (redirect) begin
      if_valid_d = 1'b0;
    end
  end

  always_comb begin
    pc_next   = pc_cur;
    imem_req  = 1'b0;
    imem_addr = pc_cur;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_next = target;
        end else if (imem_ack) begin
          pc_next = pc_inc;
        end
      end
      StStall: begin
        if (redirect) begin
          pc_next = target;
        end
      end
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (redirect) begin
          pc_next = target;
        end
      end
      default: ;
    endcase
    if (rst) begin
      pc_next  = RESET_VEC;
      imem_req = 1'b0;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur = 32'h0;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        exc_valid;
  logic [31:0] exc_vector;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_stall;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .exc_valid  (exc_valid),
    .exc_vector (exc_vector),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_stall   (if_stall)
  );

  always #5 clk = ~clk;

  // PC register model.
  always @(posedge clk) pc_cur <= pc_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each slot consumed by decode must match the next expected word.
  always @(negedge clk) begin
    if (!rst && if_valid && !if_stall) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL deliver_unexpected: got instr %h pc %h expected nothing", if_instr, if_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("deliver_instr", if_instr, e.instr);
        chk("deliver_pc", if_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rom [4];
    rom[0] = 32'h2402_0001;
    rom[1] = 32'h2403_0002;
    rom[2] = 32'h0043_2020;
    rom[3] = 32'hAC04_0100;

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; if_stall = 1'b0;
    exc_valid = 1'b0; exc_vector = 32'h0; br_taken = 1'b0; br_target = 32'h0;
    jmp_valid = 1'b0; jmp_target = 32'h0;
    tick(); tick();

    // 1: reset state, then single-cycle acks
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    rst = 1'b0; #1;
    chk("idle_req", {31'h0, imem_req}, 32'h0);
    chk("idle_pc_next", pc_next, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_rdata = rom[i]; push(rom[i], 32'(4 * i)); #1;
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_pc_next", pc_next, 32'(4 * i + 4));
      tick();
    end
    imem_ack = 1'b0; #1;
    chk("t1_pc_cur", pc_cur, 32'h10);

    // 2: ack three cycles after request
    for (int w = 0; w < 3; w++) begin
      chk("t2_req", {31'h0, imem_req}, 32'h1);
      chk("t2_addr", imem_addr, 32'h10);
      chk("t2_pc_next", pc_next, 32'h10);
      if (w == 2) chk("t2_if_valid_wait", {31'h0, if_valid}, 32'h0);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'h8C48_0010; push(32'h8C48_0010, 32'h10); #1;
    tick();
    imem_ack = 1'b0; #1;
    chk("t2_if_valid", {31'h0, if_valid}, 32'h1);
    chk("t2_pc_cur", pc_cur, 32'h14);
    chk("t2_if_pc", if_pc, 32'h10);
    tick();

    // 3: stall over two acks, second goes to skid
    if_stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h3000_0014; push(32'h3000_0014, 32'h14); #1;
    tick();
    imem_rdata = 32'h3000_0018; push(32'h3000_0018, 32'h18); #1;
    chk("t3_addr2", imem_addr, 32'h18);
    tick();
    imem_ack = 1'b0; #1;
    chk("t3_stall_req", {31'h0, imem_req}, 32'h0);
    chk("t3_stall_pc_next", pc_next, 32'h1C);
    chk("t3_stall_if_pc", if_pc, 32'h14);
    chk("t3_stall_if_valid", {31'h0, if_valid}, 32'h1);
    tick();
    chk("t3_stall_req2", {31'h0, imem_req}, 32'h0);
    if_stall = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h4000_001C; push(32'h4000_001C, 32'h1C); #1;
    chk("t3_req_resume", {31'h0, imem_req}, 32'h1);
    chk("t3_addr_resume", imem_addr, 32'h1C);
    chk("t3_skid_if_pc", if_pc, 32'h18);
    tick();

    // 4: branch while fetch of 0x20 outstanding
    imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h400; #1;
    chk("t4_pc_next", pc_next, 32'h400);
    chk("t4_addr", imem_addr, 32'h20);
    tick();
    br_taken = 1'b0; #1;
    for (int w = 0; w < 2; w++) begin
      chk("t4_drain_addr", imem_addr, 32'h20);
      chk("t4_drain_req", {31'h0, imem_req}, 32'h1);
      chk("t4_drain_if_valid", {31'h0, if_valid}, 32'h0);
      chk("t4_drain_pc_next", pc_next, 32'h400);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("t4_drain_addr_ack", imem_addr, 32'h20);
    tick();
    imem_ack = 1'b0; #1;
    chk("t4_new_addr", imem_addr, 32'h400);
    chk("t4_if_valid_dropped", {31'h0, if_valid}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h5000_0400; push(32'h5000_0400, 32'h400); #1;
    tick();
    imem_ack = 1'b0; #1;
    chk("t4_if_valid", {31'h0, if_valid}, 32'h1);

    // 5: redirect priority and alignment
    exc_valid = 1'b1; exc_vector = 32'h80; br_taken = 1'b1; br_target = 32'h400;
    jmp_valid = 1'b1; jmp_target = 32'h800; #1;
    chk("t5_priority", pc_next, 32'h80);
    exc_valid = 1'b0; br_taken = 1'b0; jmp_target = 32'h803; #1;
    chk("t5_jmp_align", pc_next, 32'h800);
    tick();
    jmp_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0404; #1;
    chk("t5_drain_addr", imem_addr, 32'h404);
    tick();
    // Redirect with ack: data dropped, PC goes to aligned exception vector.
    exc_valid = 1'b1; exc_vector = 32'hFFFF_FFFE; imem_rdata = 32'hBAD0_0800; #1;
    chk("t5_exc_ack_pc_next", pc_next, 32'hFFFF_FFFC);
    tick();
    exc_valid = 1'b0;

    // 6: wraparound, then reset mid-DRAIN
    imem_ack = 1'b1; imem_rdata = 32'h6000_FFFC; push(32'h6000_FFFC, 32'hFFFF_FFFC); #1;
    chk("t6_if_valid_flushed", {31'h0, if_valid}, 32'h0);
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t6_wrap", pc_next, 32'h0);
    tick();
    imem_ack = 1'b0; #1;
    chk("t6_pc_cur_wrap", pc_cur, 32'h0);
    chk("t6_if_valid_wrap", {31'h0, if_valid}, 32'h1);
    tick();
    br_taken = 1'b1; br_target = 32'h40; #1;
    tick();
    br_taken = 1'b0; #1;
    chk("t6_drain_addr", imem_addr, 32'h0);
    chk("t6_drain_pc_next", pc_next, 32'h40);
    rst = 1'b1; #1;
    chk("t6_rst_pc_next", pc_next, 32'h0);
    chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
    tick();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000; #1;
    chk("t6_post_rst_req", {31'h0, imem_req}, 32'h0);
    tick();
    imem_ack = 1'b0; #1;
    chk("t6_refetch_req", {31'h0, imem_req}, 32'h1);
    chk("t6_refetch_addr", imem_addr, 32'h0);
    chk("t6_late_ack_ignored", {31'h0, if_valid}, 32'h0);
    tick();
    chk("t6_late_ack_ignored2", {31'h0, if_valid}, 32'h0);
    tick(); tick();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
